// File: rtl/onehot_decoder_hold.sv
// 3-bit code to registered one-hot decoder that holds each value for HOLD_CYCLES cycles.
// Optional ONEHOT_DECODER_OVERLAP_EN: accept on the last hold cycle so out_valid never gaps.
module onehot_decoder_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out,
  output logic             out_valid,
  output logic [CNT_W-1:0] accept_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [7:0]       HOLD_M1 = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, nstate;
  logic [7:0] cnt;
  logic [7:0] dec;
  logic       accept;

  assign accept = in_valid & in_ready;
  assign dec    = 8'h01 << in_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (accept) nstate = HOLD;
      HOLD: if (cnt == 8'd0 && !accept) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
`ifdef ONEHOT_DECODER_OVERLAP_EN
      HOLD: in_ready = (cnt == 8'd0);
`else
      HOLD: in_ready = 1'b0;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  // Any accept (from IDLE, or from the final HOLD cycle when overlapping) reloads the hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= 8'h00;
      out_valid <= 1'b0;
      cnt       <= 8'd0;
    end else if (accept) begin
      out       <= dec;
      out_valid <= 1'b1;
      cnt       <= HOLD_M1;
    end else if (state == HOLD) begin
      if (cnt == 8'd0) begin
        out       <= 8'h00;
        out_valid <= 1'b0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               accept_cnt <= '0;
    else if (accept && accept_cnt != CNT_MAX) accept_cnt <= accept_cnt + 1'b1;
  end

endmodule

// File: tb/tb_onehot_decoder_hold.sv
// Randomized scoreboard bench for onehot_decoder_hold; honours ONEHOT_DECODER_OVERLAP_EN.
module tb_onehot_decoder_hold;

  localparam int HOLD    = 4;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef ONEHOT_DECODER_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    in_code = 3'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out;
  logic          out_valid;
  logic [CW-1:0] accept_cnt;

  onehot_decoder_hold #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       ov;
    logic       rdy;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: which code is shown and how many display cycles remain.
  int m_code = -1;
  int m_left = 0;
  int m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (m_left == 0) || (OV && m_left == 1);
  endfunction

  task automatic cycle(input logic v, input logic [2:0] c, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_code  = c;
    acc = v && model_ready();
    if (acc) begin
      m_code = int'(c);
      m_left = HOLD;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_code = -1;
    end
    e.out = (m_code >= 0) ? 8'(1 << m_code) : 8'h00;
    e.ov  = (m_left > 0);
    e.rdy = model_ready();
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out", 32'(out), 32'(e.out));
        chk("out_valid", 32'(out_valid), 32'(e.ov));
        chk("in_ready", 32'(in_ready), 32'(e.rdy));
        chk("accept_cnt", 32'(accept_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    bit         acc;
    logic [2:0] code;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_accept_cnt", 32'(accept_cnt), 32'h0);

    // sweep codes 0..7, each presented until taken
    code = 3'd0;
    for (int n = 0; n < 80; n++) begin
      cycle(1'b1, code, acc);
      if (acc) begin
        if (code == 3'd7) break;
        code = code + 3'd1;
      end
    end
    repeat (HOLD + 2) cycle(1'b0, 3'($urandom), acc);

    // continuous backpressure with a fixed code
    repeat (22) cycle(1'b1, 3'd5, acc);
    repeat (HOLD + 2) cycle(1'b0, 3'($urandom), acc);

    // async reset two cycles into a hold of code 7
    cycle(1'b1, 3'd7, acc);
    chk("rst_test_accept", 32'(acc), 32'h1);
    cycle(1'b0, 3'd0, acc);
    cycle(1'b0, 3'd0, acc);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midhold_out", 32'(out), 32'h0);
    chk("midhold_out_valid", 32'(out_valid), 32'h0);
    chk("midhold_accept_cnt", 32'(accept_cnt), 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_code = -1;
    m_left = 0;
    m_cnt  = 0;
    cycle(1'b1, 3'd2, acc);
    chk("post_rst_accept", 32'(acc), 32'h1);

    // random traffic
    for (int n = 0; n < 400; n++)
      cycle(($urandom_range(0, 9) < 6), 3'($urandom), acc);
    repeat (HOLD + 2) cycle(1'b0, 3'($urandom), acc);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_hold.md
Name: onehot_decoder_hold

Overview:
- Receive side of the 8:3 priority encoder link: accepts a 3-bit code plus valid flag and drives a registered one-hot 8-bit output.
- Holds each decoded output for a programmable number of cycles, e.g. to drive indicator LEDs or strobes.
- Applies ready/valid backpressure while holding, and keeps a saturating count of accepted codes.
- Sits downstream of the encoder, whose out/valid pair maps directly to in_code/in_valid.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot output stays asserted; legal range 1..255.
- CNT_W, 16, width of the accepted-code counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_code  input  3  binary code, 0..7; ignored when in_valid=0
- in_valid  input  1  code present, driven from encoder valid
- in_ready  output  1  block can accept this cycle (combinational from state/counter)
- out  output  8  registered one-hot decode, bit[in_code] set
- out_valid  output  1  out holds a decoded value
- accept_cnt  output  CNT_W  number of accepted codes, saturating

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset (async, immediate): state=IDLE, out=8'h00, out_valid=0, hold counter=0, accept_cnt=0. Asserting rst mid-HOLD clears out/out_valid at once, without waiting for a clock edge. First acceptance is possible on the first clock edge after rst deasserts.
- Accept: an accept occurs on any rising edge where in_valid=1 and in_ready=1.
- FSM state IDLE:
  - in_ready=1.
  - On accept: out <= 8'b1 << in_code, out_valid <= 1, cnt <= HOLD_CYCLES-1, go to HOLD.
  - Latency: out is visible one cycle after acceptance.
- FSM state HOLD:
  - in_ready=0 (see Optional Feature).
  - cnt decrements by 1 each cycle.
  - When cnt==0 at a clock edge: out <= 0, out_valid <= 0, go to IDLE.
  - out/out_valid are therefore high for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: one-cycle pulse; the next acceptance is possible 2 cycles after the previous one.
- Throughput without the optional feature: one code per HOLD_CYCLES+1 cycles.
- in_valid while in HOLD (not ready): ignored, no latching. The upstream is responsible for holding the code until ready.
- Output guarantee: out is always one-hot when out_valid=1 and all-zero when out_valid=0.
- accept_cnt: +1 per acceptance; saturates at 2^CNT_W-1 and never wraps. Cleared only by rst.
- Code width: in_code is always a full 3-bit value, and every value 0..7 is legal. Unknown bits in in_code are don't-care when in_valid=0.

Optional Feature:
- Macro: ONEHOT_DECODER_OVERLAP_EN.
- Defined:
  - In HOLD with cnt==0, in_ready=1.
  - An acceptance on that edge loads the new one-hot value, reloads cnt=HOLD_CYCLES-1 and stays in HOLD.
  - out_valid stays 1 continuously (no gap cycle), and out switches directly from the old one-hot value to the new one.
  - Throughput: one code per HOLD_CYCLES cycles.
- Undefined: in_ready=0 throughout HOLD; exactly one idle cycle with out=0 between consecutive holds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> out=8'h00, out_valid=0, in_ready=1, accept_cnt=0.
- Single code, HOLD_CYCLES=4: in_code=3, in_valid=1 for one cycle -> from the next cycle out=8'b00001000, out_valid=1 for exactly 4 cycles, in_ready=0 during those cycles, then out=0, accept_cnt=1.
- Code sweep: in_code 0..7, each presented when in_ready=1 -> outputs 01,02,04,...,80 in order, each held 4 cycles, accept_cnt=8.
- Backpressure: hold in_valid=1 with in_code=5 continuously -> new acceptance only every 5 cycles (4 with OVERLAP_EN), out=8'h20 each time, and with OVERLAP_EN out_valid never drops.
- Reset mid-hold: assert rst asynchronously 2 cycles into a hold of code 7 -> out=0 and out_valid=0 before the next clk edge, accept_cnt=0, and a fresh accept works after release.
- Saturation with CNT_W=2: perform 5 acceptances -> accept_cnt reads 1,2,3,3,3.
